// File: rtl/dnn_mlp_fix_param.sv
// Two-layer fixed-point MLP inference engine with a single shared read port.
// Each neuron runs a serial MAC followed by a sigmoid LUT lookup in memory.
// Optional feature macro: DNN_ARGMAX_EN adds an incremental argmax on class_idx.
module dnn_mlp_fix_param #(
  parameter int unsigned                  DATA_WIDTH       = 2,
  parameter int unsigned                  ADDR_WIDTH       = 16,
  parameter int unsigned                  N_IN             = 400,
  parameter int unsigned                  N_HID            = 25,
  parameter int unsigned                  N_OUT            = 10,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_A      = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_W      = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_LUT_L1 = 16'h29be,
  parameter logic [ADDR_WIDTH-1:0]        ADDR_BASE_LUT_L2 = 16'h29c2,
  parameter logic signed [DATA_WIDTH-1:0] L1_ONE_BIAS_VAL  = 2'b01,
  parameter logic signed [DATA_WIDTH-1:0] L2_ONE_BIAS_VAL  = 2'b01,
  parameter int unsigned                  ACC_WIDTH        = 24,
  parameter int unsigned                  LUT_IDX_WIDTH    = 2,
  parameter int unsigned                  ACC_SHIFT        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                clear,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic signed [DATA_WIDTH-1:0]        mem_data,
  output logic                                done,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0]    out,
  output logic [$clog2(N_OUT)-1:0]            class_idx
);

  localparam int unsigned CNT_MAX_L1 = 2 * N_IN + 1;
  localparam int unsigned CNT_MAX_L2 = N_HID + 1;
  localparam int unsigned CNT_W      = $clog2((CNT_MAX_L1 > CNT_MAX_L2 ? CNT_MAX_L1 : CNT_MAX_L2) + 1);
  localparam int unsigned NEU_W      = $clog2((N_HID > N_OUT ? N_HID : N_OUT) + 1);
  localparam int unsigned L2_W_OFF   = N_HID * (N_IN + 1);
  localparam int unsigned LUT_OFF    = 1 << (LUT_IDX_WIDTH - 1);
  localparam int unsigned PROD_W     = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] IDX_MAX = ACC_WIDTH'(LUT_OFF - 1);
  localparam logic signed [ACC_WIDTH-1:0] IDX_MIN = ~IDX_MAX;

  typedef enum logic [2:0] {
    IDLE, L1_MAC, L1_LUT, L1_LUTW, L2_MAC, L2_LUT, L2_LUTW, DONE
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt;
  logic [NEU_W-1:0]                r_neu;
  logic signed [ACC_WIDTH-1:0]     r_acc;
  logic signed [DATA_WIDTH-1:0]    r_act;
  logic signed [DATA_WIDTH-1:0]    r_hid [N_HID];
  logic [N_OUT-1:0][DATA_WIDTH-1:0] r_out;
  logic                            r_done;

  logic [ADDR_WIDTH-1:0]           w_addr;
  logic                            w_mul_en;
  logic                            w_act_ld;
  logic signed [DATA_WIDTH-1:0]    w_mul_a;
  logic signed [PROD_W-1:0]        w_prod;
  logic [ACC_WIDTH-1:0]            w_prod_ext;
  logic signed [ACC_WIDTH-1:0]     w_shift;
  logic signed [LUT_IDX_WIDTH-1:0] w_idx;
  logic [LUT_IDX_WIDTH-1:0]        w_lut_off;

  assign mem_addr   = w_addr;
  assign done       = r_done;
  assign out        = r_out;
  assign w_prod     = w_mul_a * mem_data;
  assign w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = L1_MAC;
      L1_MAC:     if (r_cnt == CNT_W'(CNT_MAX_L1)) w_state_nxt = L1_LUT;
      L1_LUT:     w_state_nxt = L1_LUTW;
      L1_LUTW:    w_state_nxt = (r_neu == NEU_W'(N_HID - 1)) ? L2_MAC : L1_MAC;
      L2_MAC:     if (r_cnt == CNT_W'(CNT_MAX_L2)) w_state_nxt = L2_LUT;
      L2_LUT:     w_state_nxt = L2_LUTW;
      L2_LUTW:    w_state_nxt = (r_neu == NEU_W'(N_OUT - 1)) ? DONE : L2_MAC;
      default:    w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // Saturating LUT index from the shifted accumulator
  always_comb begin
    w_shift = r_acc >>> ACC_SHIFT;
    if (w_shift > IDX_MAX)      w_idx = LUT_IDX_WIDTH'(IDX_MAX);
    else if (w_shift < IDX_MIN) w_idx = LUT_IDX_WIDTH'(IDX_MIN);
    else                        w_idx = LUT_IDX_WIDTH'(w_shift);
    w_lut_off = LUT_IDX_WIDTH'(w_idx) + LUT_IDX_WIDTH'(LUT_OFF);
  end

  // Read address issue and MAC operand select (data lags address by one cycle)
  always_comb begin
    w_addr   = ADDR_BASE_A;
    w_mul_en = 1'b0;
    w_act_ld = 1'b0;
    w_mul_a  = '0;
    case (r_state)
      L1_MAC: begin
        if (r_cnt < CNT_W'(2 * N_IN)) begin
          if (r_cnt[0]) w_addr = ADDR_BASE_W + ADDR_WIDTH'(32'(r_neu) * (N_IN + 1) + 32'(r_cnt >> 1));
          else          w_addr = ADDR_BASE_A + ADDR_WIDTH'(r_cnt >> 1);
        end else if (r_cnt == CNT_W'(2 * N_IN)) begin
          w_addr = ADDR_BASE_W + ADDR_WIDTH'(32'(r_neu) * (N_IN + 1) + N_IN);
        end
        if (r_cnt == CNT_W'(CNT_MAX_L1)) begin
          w_mul_en = 1'b1;
          w_mul_a  = L1_ONE_BIAS_VAL;
        end else if (r_cnt[0]) begin
          w_act_ld = 1'b1;
        end else if (r_cnt != '0) begin
          w_mul_en = 1'b1;
          w_mul_a  = r_act;
        end
      end
      L2_MAC: begin
        if (r_cnt <= CNT_W'(N_HID))
          w_addr = ADDR_BASE_W + ADDR_WIDTH'(L2_W_OFF + 32'(r_neu) * (N_HID + 1) + 32'(r_cnt));
        if (r_cnt == CNT_W'(CNT_MAX_L2)) begin
          w_mul_en = 1'b1;
          w_mul_a  = L2_ONE_BIAS_VAL;
        end else if (r_cnt != '0) begin
          w_mul_en = 1'b1;
          for (int j = 0; j < int'(N_HID); j++)
            if (int'(r_cnt) == j + 1) w_mul_a = r_hid[j];
        end
      end
      L1_LUT:  w_addr = ADDR_BASE_LUT_L1 + ADDR_WIDTH'(w_lut_off);
      L2_LUT:  w_addr = ADDR_BASE_LUT_L2 + ADDR_WIDTH'(w_lut_off);
      default: w_addr = ADDR_BASE_A;
    endcase
  end

  // Datapath: counters, accumulator, hidden and output captures, done flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt  <= '0;
      r_neu  <= '0;
      r_acc  <= '0;
      r_act  <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
      for (int h = 0; h < int'(N_HID); h++) r_hid[h] <= '0;
    end else begin
      r_done <= (r_state == DONE) && (w_state_nxt == DONE);
      r_cnt  <= ((r_state == L1_MAC || r_state == L2_MAC) && w_state_nxt == r_state)
                ? r_cnt + CNT_W'(1) : '0;
      case (r_state)
        L1_MAC, L2_MAC: begin
          if (r_cnt == '0)   r_acc <= '0;
          else if (w_mul_en) r_acc <= r_acc + w_prod_ext;
          if (w_act_ld)      r_act <= mem_data;
        end
        L1_LUTW: begin
          for (int h = 0; h < int'(N_HID); h++)
            if (int'(r_neu) == h) r_hid[h] <= mem_data;
          r_neu <= (r_neu == NEU_W'(N_HID - 1)) ? '0 : r_neu + NEU_W'(1);
        end
        L2_LUTW: begin
          for (int k = 0; k < int'(N_OUT); k++)
            if (int'(r_neu) == k) r_out[k] <= mem_data;
          r_neu <= r_neu + NEU_W'(1);
        end
        IDLE, DONE: r_neu <= '0;
        default: ;
      endcase
    end
  end

`ifdef DNN_ARGMAX_EN
  localparam int unsigned CLS_W = $clog2(N_OUT);
  logic signed [DATA_WIDTH-1:0] r_best;
  logic [CLS_W-1:0]             r_cls;

  // Running argmax; only a strictly larger entry replaces, so ties keep the lowest index
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_best <= '0;
      r_cls  <= '0;
    end else if (r_state == L2_LUTW) begin
      if (r_neu == '0 || mem_data > r_best) begin
        r_best <= mem_data;
        r_cls  <= CLS_W'(r_neu);
      end
    end
  end

  assign class_idx = r_cls;
`else
  assign class_idx = '0;
`endif

endmodule

// File: doc/dnn_mlp_fix_param.md
DNN_MLP_FIX_PARAM -- requirements
Module: dnn_mlp_fix_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, signed width of activations, weights and LUT entries.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 SHALL have parameters N_IN=400, N_HID=25, N_OUT=10, the input, hidden and output neuron counts.
REQ-004 SHALL have parameters ADDR_BASE_A=16'h0000, ADDR_BASE_W=16'h0191, ADDR_BASE_LUT_L1=16'h29be, ADDR_BASE_LUT_L2=16'h29c2, the memory region bases.
REQ-005 SHALL have parameters L1_ONE_BIAS_VAL=2'b01 and L2_ONE_BIAS_VAL=2'b01, the constant bias inputs per layer.
REQ-006 SHALL have parameters ACC_WIDTH=24 (accumulator width), LUT_IDX_WIDTH=2 (signed LUT index width) and ACC_SHIFT=0 (arithmetic right shift before indexing).
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  begin one inference when sampled high in IDLE or DONE.
REQ-010 clear  input  1  synchronous soft abort to IDLE.
REQ-011 mem_addr  output  ADDR_WIDTH  read address; data returns the next cycle.
REQ-012 mem_data  input  DATA_WIDTH signed  read data for the previous cycle's mem_addr.
REQ-013 done  output  1  level; high in DONE.
REQ-014 out  output  DATA_WIDTH signed x N_OUT  layer-2 sigmoid outputs.
REQ-015 class_idx  output  $clog2(N_OUT)  argmax of out.

Function
REQ-016 FSM states SHALL be IDLE, L1_MAC, L1_LUT, L1_LUTW, L2_MAC, L2_LUT, L2_LUTW and DONE; start moves IDLE/DONE->L1_MAC for hidden 0.
REQ-017 Weight layout SHALL be: hidden h, input i at ADDR_BASE_W+h*(N_IN+1)+i (i=N_IN is bias); output k, hidden j at ADDR_BASE_W+N_HID*(N_IN+1)+k*(N_HID+1)+j (j=N_HID is bias).
REQ-018 L1_MAC SHALL alternate reads: activation ADDR_BASE_A+i, then weight, for each i; then one bias-weight read multiplied by L1_ONE_BIAS_VAL; 2*N_IN+1 issue cycles plus 1 drain cycle.
REQ-019 L2_MAC SHALL read only weights and multiply by internal hidden registers, with the bias read multiplied by L2_ONE_BIAS_VAL; N_HID+1 issue cycles plus 1 drain cycle.
REQ-020 Products SHALL be signed DATA_WIDTH x DATA_WIDTH, sign-extended to ACC_WIDTH and accumulated with two's-complement wrap; the accumulator clears at each neuron start.
REQ-021 LUT index SHALL be acc>>>ACC_SHIFT saturated to the signed LUT_IDX_WIDTH range; LUT address = layer base + index + 2^(LUT_IDX_WIDTH-1); *_LUT issues the address and *_LUTW captures the entry.
REQ-022 Captured L1 entries SHALL go to hidden register h; captured L2 entries SHALL go to out[k].
REQ-023 Per-neuron cycles SHALL be 2*N_IN+4 (L1) and N_HID+4 (L2); done SHALL rise exactly 1+N_HID*(2*N_IN+4)+N_OUT*(N_HID+4) cycles after start is sampled.
REQ-024 done SHALL stay high in DONE until clear or start; start in DONE SHALL drop done next cycle and restart.
REQ-025 start SHALL be ignored while busy.
REQ-026 clear SHALL return the FSM to IDLE next cycle, drive done=0 and zero out, class_idx and the hidden registers; clear SHALL win over a simultaneous start.
REQ-027 mem_addr SHALL equal ADDR_BASE_A in IDLE and DONE.

Reset
REQ-028 rst SHALL force IDLE, done=0, out all 0, class_idx=0, accumulator and hidden registers 0, mem_addr=ADDR_BASE_A, and SHALL take priority over clear and start, including mid-inference.

Configuration
REQ-029 With DNN_ARGMAX_EN defined, class_idx SHALL update incrementally at each L2_LUTW capture, strictly-greater replaces and ties keep the lowest index, and SHALL be final when done rises, with no added latency.
REQ-030 Without DNN_ARGMAX_EN, class_idx SHALL be constant 0, no comparator logic SHALL exist, and timing SHALL be unchanged.

Verification
Bench config for REQ-031..REQ-034: N_IN=4, N_HID=2, N_OUT=3, DATA_WIDTH=2, LUT_IDX_WIDTH=2, ACC_SHIFT=0; expected latency = 43 cycles.
REQ-031 Latency: activations all 1, weights all 1, L1 LUT {-2,-1,0,1}, L2 LUT {0,1,1,1}, start pulse -> hidden acc=5 saturates to index 1, entry 1; L2 acc=3 gives out={1,1,1}, class_idx=0, done rises on cycle 43.
REQ-032 Argmax: output 2 weights all 1 and outputs 0 and 1 weights all -1, L2 LUT identity {-2,-1,0,1} -> out={-2,-2,1}, class_idx=2.
REQ-033 Abort: clear at cycle 20 with start also high -> IDLE next cycle, done=0, out=0; a later start yields the REQ-031 result at exactly 43 cycles.
REQ-034 Reset mid-run: rst at cycle 30 -> all outputs at reset values next cycle, mem_addr=16'h0000; start while busy (cycle 10) is ignored and latency is unchanged.
REQ-035 Default parameters, macro undefined, random image against a golden model -> out matches bit-exactly, class_idx=0, done after 1+25*804+10*29=20391 cycles.
